// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift type encodings, widths and operand bundle
package shift_pkg;

    localparam int SHIFT_DATA_W = 64;
    localparam int SHIFT_AMT_W  = 6;

    typedef enum logic [2:0] {
        SH_LL  = 3'd0,
        SH_RL  = 3'd1,
        SH_LA  = 3'd2,
        SH_RA  = 3'd3,
        SH_ROL = 3'd4,
        SH_ROR = 3'd5
    } shift_type_e;

    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] data;
        shift_type_e             shtype;
        logic [SHIFT_AMT_W-1:0]  shamt;
    } shift_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sequencer sharing one barrel shifter among NUM_REQ requesters
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = SHIFT_DATA_W,
    parameter int SHAMT_W = SHIFT_AMT_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_in,
    input  logic [NUM_REQ-1:0][2:0]          req_type,
    input  logic [NUM_REQ-1:0][SHAMT_W-1:0]  req_shamt,
    output logic [DATA_W-1:0]                sh_in,
    output logic [2:0]                       sh_type,
    output logic [SHAMT_W-1:0]               sh_amount,
    input  logic [DATA_W-1:0]                sh_result,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_W-1:0]                rsp_data,
    output logic [ID_W-1:0]                  rsp_id
);

    logic [ID_W-1:0]    rr_ptr;
    logic               op_valid;
    logic [DATA_W-1:0]  op_in;
    logic [2:0]         op_type;
    logic [SHAMT_W-1:0] op_shamt;
    logic [ID_W-1:0]    op_id;

    logic               rsp_free;
    logic               op_adv;
    logic               op_free;
    logic               grant;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;

    assign rsp_free = !rsp_valid || rsp_ready;
    assign op_adv   = op_valid && rsp_free;
    assign op_free  = !op_valid || op_adv;

    // rst_n gates the grant so no requester sees ready while reset is held
    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (op_free && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    assign sh_in     = op_in;
    assign sh_type   = op_type;
    assign sh_amount = op_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            op_valid <= 1'b0;
            op_in    <= '0;
            op_type  <= '0;
            op_shamt <= '0;
            op_id    <= '0;
        end else begin
            if (grant) begin
                op_valid <= 1'b1;
                op_in    <= req_in[gnt_idx];
                op_type  <= req_type[gnt_idx];
                op_shamt <= req_shamt[gnt_idx];
                op_id    <= gnt_idx;
                rr_ptr   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (op_adv) begin
                op_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (op_adv) begin
                rsp_valid <= 1'b1;
                rsp_data  <= sh_result;
                rsp_id    <= op_id;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
